mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single unified memory port between the instruction-fetch requester and the data-access requester (load/store driven by the decoder's `o_dmem_ren` and `o_dmem_wen`) for the multi-cycle core. The block:
- issues one transaction at a time over a ready/valid memory interface;
- returns read data to the granted requester;
- drives a pipeline stall while any request is unserved.

Data accesses have priority over fetches, because they belong to the older instruction.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Byte mask width is `DATA_W/8`.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: the single clock. All logic is on the rising edge.
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_if_req`, in, 1: fetch request. Held until `o_if_valid`.
- `i_if_addr`, in, `ADDR_W`: fetch address.
- `o_if_rdata`, out, `DATA_W`: fetched word. Valid with `o_if_valid`.
- `o_if_valid`, out, 1: one-cycle fetch-complete pulse.
- `i_d_ren`, in, 1: data read request. Held until `o_d_valid`.
- `i_d_wen`, in, 1: data write request. Held until `o_d_valid`.
- `i_d_addr`, in, `ADDR_W`: data address.
- `i_d_wdata`, in, `DATA_W`: store data.
- `i_d_mask`, in, `DATA_W/8`: store byte enables.
- `o_d_rdata`, out, `DATA_W`: load data. Valid with `o_d_valid`.
- `o_d_valid`, out, 1: one-cycle pulse. Marks data-access completion, for both read and write.
- `o_stall`, out, 1: pipeline stall.
- `o_mem_addr`, out, `ADDR_W`: memory command address.
- `o_mem_ren`, out, 1: memory read command.
- `o_mem_wen`, out, 1: memory write command.
- `o_mem_wdata`, out, `DATA_W`: memory write data.
- `o_mem_mask`, out, `DATA_W/8`: memory byte enables.
- `i_mem_ready`, in, 1: memory accepts the command this cycle.
- `i_mem_rdata`, in, `DATA_W`: memory read data.
- `i_mem_valid`, in, 1: response or write acknowledge.
- `o_timeout`, out, 1: sticky watchdog flag. This port exists only with `MEM_ARB_TIMEOUT_EN`.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. The reset state is IDLE.
- **IDLE:**
  - A data request (`i_d_ren|i_d_wen`) wins over `i_if_req`.
  - On a winning request, register the grant, address, wdata, mask and command type, then go to ISSUE.
  - If no request is present, stay in IDLE.
  - If `i_d_ren` and `i_d_wen` are both high, the access is treated as a write.
- **ISSUE:**
  - `o_mem_*` is driven from the registered command.
  - On an edge with `i_mem_ready=1`, go to WAIT. `o_mem_ren`/`o_mem_wen` drop in the same edge.
  - `i_mem_valid` is ignored in ISSUE.
- **WAIT:**
  - The command lines are low.
  - On an edge with `i_mem_valid=1`, capture `i_mem_rdata` into the granted requester's rdata register, go to RESP, and set that requester's valid.
  - Writes capture nothing. `o_d_rdata` holds its prior value.
- **RESP:**
  - The granted valid pulses high for exactly this one cycle.
  - All requests are ignored in RESP. The served requester drops or changes its request on this edge.
  - The next state is always IDLE.
- `o_stall = (i_if_req & ~o_if_valid) | ((i_d_ren|i_d_wen) & ~o_d_valid)`. This is combinational on registered state.
- Only the rdata of the granted side updates. The other side's rdata holds.
- A request arriving while a transaction is outstanding waits. It is arbitrated in the next IDLE.

## Timing
- Reset values:
  - state is IDLE;
  - all `o_*` are 0, including the rdata registers and `o_timeout`.
- Reset is synchronous and applies mid-transaction. After reset:
  - any in-flight response is dropped;
  - an `i_mem_valid` arriving in IDLE is ignored.
- Minimum latency from request to valid pulse is 3 cycles:
  - C0: IDLE samples the request.
  - C1: ISSUE, with `i_mem_ready=1`.
  - C2: WAIT, with `i_mem_valid=1`.
  - C3: RESP, valid high.
- Back-to-back throughput is one transaction per 4 cycles minimum.
- Any stall of `i_mem_ready` or `i_mem_valid` extends ISSUE or WAIT by one cycle per low cycle.
- The requester must keep its address and data stable from assertion until its valid pulse. Values are sampled once, in IDLE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT.
  - When the counter reaches `TIMEOUT_CYCLES`:
    - abort to RESP;
    - pulse the granted valid with rdata 0;
    - set `o_timeout`, which stays high until `i_rst`;
    - drop the memory command.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - there is no counter and no `o_timeout` port;
  - ISSUE and WAIT wait indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum` for the state (IDLE, ISSUE, WAIT, RESP);
  - `typedef enum` for the grant (`GNT_IF`, `GNT_D`);
  - default width constants.
- Optional sub-module `mem_arb_watchdog`: the timeout counter and sticky flag. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Single fetch:**
  - Stimulus: `i_if_req=1`, `i_if_addr=0x100`; memory drives ready in C1 and valid with `0xDEADBEEF` in C2.
  - Required: `o_mem_addr=0x100`, `o_mem_ren=1` in C1 only; `o_if_valid` pulses in C3 with `o_if_rdata=0xDEADBEEF`; `o_stall` is high in C0–C2 and low in C3.
- **Simultaneous requests:**
  - Stimulus: `i_if_req` and `i_d_ren` (addr `0x2000`) both asserted in C0.
  - Required: the data access is issued first and `o_d_valid` pulses; the fetch is then issued in the following IDLE, with `o_if_valid` 4 cycles later.
- **Store:**
  - Stimulus: `i_d_wen=1`, addr `0x40`, wdata `0x12345678`, mask `4'b0011`.
  - Required: `o_mem_wen=1` with those values; `o_d_valid` pulses; `o_d_rdata` is unchanged.
- **Backpressure:**
  - Stimulus: `i_mem_ready` low for 5 cycles, then `i_mem_valid` low for 3 cycles.
  - Required: command held stable for 6 ISSUE cycles; valid pulse at C0+11.
- **Reset mid-WAIT:**
  - Stimulus: `i_rst` in WAIT, then a stray `i_mem_valid` the cycle after.
  - Required: all outputs 0; no valid pulse; FSM in IDLE.
- **Timeout (macro on, `TIMEOUT_CYCLES=8`):**
  - Stimulus: memory never responds.
  - Required: after 8 cycles in ISSUE/WAIT, the valid pulse arrives with rdata 0; `o_timeout=1` persists until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Brief   : Shared types and default widths for the unified memory-port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned c_ADDR_W_DEF  = 32;
  localparam int unsigned c_DATA_W_DEF  = 32;
  localparam int unsigned c_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
//------------------------------------------------------------------------------
// Module  : mem_arb_watchdog
// Brief   : Transaction timeout counter with sticky flag (MEM_ARB_TIMEOUT_EN builds).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_active,
  output logic o_expire,
  output logic o_timeout
);

  localparam int                c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;
  logic               r_timeout;

  // Expires on the last allowed ISSUE/WAIT cycle so the abort edge lands exactly at the limit
  assign o_expire  = i_active && (r_count == c_LAST);
  assign o_timeout = r_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (i_start) begin
        r_count <= '0;
      end else if (i_active && !o_expire) begin
        r_count <= r_count + 1'b1;
      end
      if (o_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Brief   : Shares one ready/valid memory port between fetch and data requesters,
//           data first. Optional watchdog under macro MEM_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = c_ADDR_W_DEF,
  parameter int DATA_W         = c_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_valid,
  input  logic                i_d_ren,
  input  logic                i_d_wen,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_mask,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_valid,
  output logic                o_stall,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_ren,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_ready,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_valid
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                o_timeout
`endif
);

  localparam int c_MASK_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  arb_gnt_t            r_gnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_MASK_W-1:0] r_mask;
  logic                r_is_write;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_valid;
  logic                r_d_valid;

  logic w_d_req;
  logic w_take;
  logic w_done;
  logic w_abort;

  assign w_d_req = i_d_ren | i_d_wen;
  assign w_take  = (r_state == IDLE) && (w_d_req || i_if_req);
  assign w_done  = (r_state == WAIT) && i_mem_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_take),
    .i_active  ((r_state == ISSUE) || (r_state == WAIT)),
    .o_expire  (w_abort),
    .o_timeout (o_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES[0];
  assign w_abort          = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = ISSUE;
      ISSUE: begin
        if (w_abort)          w_state_nxt = RESP;
        else if (i_mem_ready) w_state_nxt = WAIT;
      end
      WAIT:    if (w_abort || i_mem_valid) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_IF;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_is_write <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_take) begin
        r_gnt      <= w_d_req ? GNT_D : GNT_IF;
        r_addr     <= w_d_req ? i_d_addr : i_if_addr;
        r_wdata    <= w_d_req ? i_d_wdata : '0;
        r_mask     <= w_d_req ? i_d_mask : '0;
        r_is_write <= i_d_wen;
      end
      // An aborted transaction still completes toward the requester, with zero data
      if (w_abort) begin
        if (r_gnt == GNT_D) begin
          r_d_valid <= 1'b1;
          r_d_rdata <= '0;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= '0;
        end
      end else if (w_done) begin
        if (r_gnt == GNT_D) begin
          r_d_valid <= 1'b1;
          if (!r_is_write) r_d_rdata <= i_mem_rdata;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_mask  = r_mask;
  assign o_mem_ren   = (r_state == ISSUE) && !r_is_write;
  assign o_mem_wen   = (r_state == ISSUE) && r_is_write;

  assign o_if_rdata = r_if_rdata;
  assign o_if_valid = r_if_valid;
  assign o_d_rdata  = r_d_rdata;
  assign o_d_valid  = r_d_valid;

  assign o_stall = (i_if_req & ~r_if_valid) | (w_d_req & ~r_d_valid);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_port_arbiter
// Brief   : Directed scoreboard bench for mem_port_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_d_ren;
  logic        i_d_wen;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic [31:0] o_d_rdata;
  logic        o_d_valid;
  logic        o_stall;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        o_timeout;
`endif

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
`ifdef MEM_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES (8)
`else
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_valid  (o_if_valid),
    .i_d_ren     (i_d_ren),
    .i_d_wen     (i_d_wen),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .i_d_mask    (i_d_mask),
    .o_d_rdata   (o_d_rdata),
    .o_d_valid   (o_d_valid),
    .o_stall     (o_stall),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ren   (o_mem_ren),
    .o_mem_wen   (o_mem_wen),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_valid (i_mem_valid)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  typedef struct {
    string       name;
    bit          side;   // 0 = fetch, 1 = data
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   c0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input bit side, input logic [31:0] data, input int c);
    exp_t e;
    e.name = name;
    e.side = side;
    e.data = data;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic sb_check(input bit side, input logic [31:0] data);
    exp_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: side %0d valid at cycle %0d rdata 0x%08h, want no pulse",
               side, cyc, data);
    end else begin
      e = q.pop_front();
      if (e.side !== side || e.data !== data || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_%s: side %0d rdata 0x%08h cycle %0d, want side %0d rdata 0x%08h cycle %0d",
                 e.name, side, data, cyc, e.side, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_d_valid)  sb_check(1'b1, o_d_rdata);
      if (o_if_valid) sb_check(1'b0, o_if_rdata);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL tb_time_limit: simulation still running, want completion");
    $fatal(1, "time limit");
  end

  initial begin
    i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0;
    i_d_ren = 1'b0; i_d_wen = 1'b0; i_d_addr = '0; i_d_wdata = '0; i_d_mask = '0;
    i_mem_ready = 1'b0; i_mem_rdata = '0; i_mem_valid = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;

    // Reset state
    mid();
    chk("rst_if_valid", o_if_valid, 0);
    chk("rst_d_valid",  o_d_valid, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_d_rdata",  o_d_rdata, 0);
    chk("rst_mem_ren",  o_mem_ren, 0);
    chk("rst_mem_wen",  o_mem_wen, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_stall",    o_stall, 0);
    tick();

    // Single fetch
    i_if_req = 1'b1; i_if_addr = 32'h100; c0 = cyc;
    push_exp("fetch", 1'b0, 32'hDEADBEEF, c0 + 3);
    mid(); chk("fetch_c0_stall", o_stall, 1); chk("fetch_c0_ren", o_mem_ren, 0);
    tick(); i_mem_ready = 1'b1;
    mid(); chk("fetch_c1_addr", o_mem_addr, 32'h100); chk("fetch_c1_ren", o_mem_ren, 1);
    chk("fetch_c1_stall", o_stall, 1);
    tick(); i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    mid(); chk("fetch_c2_ren", o_mem_ren, 0); chk("fetch_c2_stall", o_stall, 1);
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid(); chk("fetch_c3_stall", o_stall, 0);
    tick(); i_if_req = 1'b0;
    tick();

    // Simultaneous fetch and load: data first
    i_if_req = 1'b1; i_if_addr = 32'h300; i_d_ren = 1'b1; i_d_addr = 32'h2000; c0 = cyc;
    push_exp("simul_d",  1'b1, 32'hCAFE0001, c0 + 3);
    push_exp("simul_if", 1'b0, 32'hA5A5A5A5, c0 + 7);
    mid(); chk("simul_c0_stall", o_stall, 1);
    tick(); i_mem_ready = 1'b1;
    mid(); chk("simul_c1_addr", o_mem_addr, 32'h2000); chk("simul_c1_ren", o_mem_ren, 1);
    tick(); i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hCAFE0001;
    mid();
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid(); chk("simul_c3_stall_fetch_pending", o_stall, 1);
    chk("simul_c3_if_rdata_held", o_if_rdata, 32'hDEADBEEF);
    tick(); i_d_ren = 1'b0;
    mid(); chk("simul_c4_idle_ren", o_mem_ren, 0);
    tick(); i_mem_ready = 1'b1;
    mid(); chk("simul_c5_addr", o_mem_addr, 32'h300); chk("simul_c5_ren", o_mem_ren, 1);
    tick(); i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hA5A5A5A5;
    mid();
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid(); chk("simul_c7_d_rdata_held", o_d_rdata, 32'hCAFE0001);
    tick(); i_if_req = 1'b0;
    tick();

    // Store: load data register must not change
    i_d_wen = 1'b1; i_d_addr = 32'h40; i_d_wdata = 32'h12345678; i_d_mask = 4'b0011; c0 = cyc;
    push_exp("store", 1'b1, 32'hCAFE0001, c0 + 3);
    mid();
    tick(); i_mem_ready = 1'b1;
    mid(); chk("store_wen", o_mem_wen, 1); chk("store_ren", o_mem_ren, 0);
    chk("store_addr", o_mem_addr, 32'h40); chk("store_wdata", o_mem_wdata, 32'h12345678);
    chk("store_mask", o_mem_mask, 4'b0011);
    tick(); i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    mid(); chk("store_c2_wen", o_mem_wen, 0);
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid();
    tick(); i_d_wen = 1'b0;
    tick();

    // Read and write together is a write
    i_d_ren = 1'b1; i_d_wen = 1'b1; i_d_addr = 32'h80; i_d_wdata = 32'h55; i_d_mask = 4'hF; c0 = cyc;
    push_exp("rw_both", 1'b1, 32'hCAFE0001, c0 + 3);
    mid();
    tick(); i_mem_ready = 1'b1;
    mid(); chk("rw_both_wen", o_mem_wen, 1); chk("rw_both_ren", o_mem_ren, 0);
    tick(); i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h11111111;
    mid();
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid();
    tick(); i_d_ren = 1'b0; i_d_wen = 1'b0;
    tick();

    // Backpressure: 5 not-ready cycles, then 3 not-valid cycles
    i_if_req = 1'b1; i_if_addr = 32'h500; c0 = cyc;
    push_exp("backpressure", 1'b0, 32'h0BADF00D, c0 + 11);
    mid();
    for (int k = 1; k <= 6; k++) begin
      tick(); i_mem_ready = (k == 6);
      mid(); chk($sformatf("bp_c%0d_addr", k), o_mem_addr, 32'h500);
      chk($sformatf("bp_c%0d_ren", k), o_mem_ren, 1);
    end
    for (int k = 7; k <= 10; k++) begin
      tick(); i_mem_ready = 1'b0; i_mem_valid = (k == 10);
      i_mem_rdata = (k == 10) ? 32'h0BADF00D : 32'h0;
      mid(); chk($sformatf("bp_c%0d_ren", k), o_mem_ren, 0);
    end
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid(); chk("bp_c11_stall", o_stall, 0);
    tick(); i_if_req = 1'b0;
    tick();

    // Reset in WAIT, then a stray response
    i_d_ren = 1'b1; i_d_addr = 32'h90;
    mid();
    tick(); i_mem_ready = 1'b1;
    mid();
    tick(); i_mem_ready = 1'b0; i_rst = 1'b1;
    mid();
    tick(); i_rst = 1'b0; i_d_ren = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h77777777;
    mid(); chk("rstw_d_valid", o_d_valid, 0); chk("rstw_d_rdata", o_d_rdata, 0);
    chk("rstw_if_rdata", o_if_rdata, 0); chk("rstw_mem_ren", o_mem_ren, 0);
    chk("rstw_mem_addr", o_mem_addr, 0); chk("rstw_stall", o_stall, 0);
    tick(); i_mem_valid = 1'b0; i_mem_rdata = '0;
    mid(); chk("rstw_c4_d_valid", o_d_valid, 0); chk("rstw_c4_d_rdata", o_d_rdata, 0);
    chk("rstw_c4_mem_ren", o_mem_ren, 0);
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after 8 ISSUE/WAIT cycles
    i_if_req = 1'b1; i_if_addr = 32'h600; c0 = cyc;
    push_exp("timeout", 1'b0, 32'h0, c0 + 9);
    mid();
    for (int k = 1; k <= 8; k++) begin
      tick();
      mid(); chk($sformatf("to_c%0d_ren", k), o_mem_ren, 1);
      chk($sformatf("to_c%0d_flag", k), o_timeout, 0);
    end
    tick();
    mid(); chk("to_c9_flag", o_timeout, 1); chk("to_c9_ren", o_mem_ren, 0);
    tick(); i_if_req = 1'b0;
    mid(); chk("to_c10_flag", o_timeout, 1);
    repeat (3) tick();
    mid(); chk("to_sticky", o_timeout, 1);
    tick(); i_rst = 1'b1;
    tick(); i_rst = 1'b0;
    mid(); chk("to_cleared", o_timeout, 0);
    tick();
`endif

    repeat (4) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
